// File: rtl/rv32i_enc_pkg.sv
// Shared RV32I encoding definitions: opcodes, instruction classes, per-class
// op counts and funct tables, and the field-level encoder used by both the
// directed-request path and the random generator.
package rv32i_enc_pkg;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_JALR   = 7'b1100111,
    OPC_SYSTEM = 7'b1110011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [3:0] {
    CLS_R    = 4'd0,
    CLS_I    = 4'd1,
    CLS_IL   = 4'd2,
    CLS_IJ   = 4'd3,
    CLS_IE   = 4'd4,
    CLS_S    = 4'd5,
    CLS_B    = 4'd6,
    CLS_J    = 4'd7,
    CLS_UL   = 4'd8,
    CLS_UAPC = 4'd9
  } class_e;

  localparam logic [3:0] NUM_CLASSES = 4'd10;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // Number of sub-ops in each class; 0 marks an illegal class.
  function automatic logic [3:0] op_count(input logic [3:0] cls);
    case (cls)
      CLS_R:    return 4'd10;
      CLS_I:    return 4'd9;
      CLS_IL:   return 4'd5;
      CLS_IJ:   return 4'd1;
      CLS_IE:   return 4'd2;
      CLS_S:    return 4'd3;
      CLS_B:    return 4'd6;
      CLS_J:    return 4'd1;
      CLS_UL:   return 4'd1;
      CLS_UAPC: return 4'd1;
      default:  return 4'd0;
    endcase
  endfunction

  // Folds an arbitrary 4-bit index into the legal sub-op range of a class.
  function automatic logic [3:0] op_mod(input logic [3:0] cls, input logic [3:0] idx);
    case (cls)
      CLS_R:   return idx % 4'd10;
      CLS_I:   return idx % 4'd9;
      CLS_IL:  return idx % 4'd5;
      CLS_IE:  return idx % 4'd2;
      CLS_S:   return idx % 4'd3;
      CLS_B:   return idx % 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [2:0] r_f3(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: return 3'd0;
      4'd2:       return 3'd1;
      4'd3:       return 3'd2;
      4'd4:       return 3'd3;
      4'd5:       return 3'd4;
      4'd6, 4'd7: return 3'd5;
      4'd8:       return 3'd6;
      default:    return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] i_f3(input logic [3:0] op);
    case (op)
      4'd0:    return 3'd0;
      4'd1:    return 3'd2;
      4'd2:    return 3'd3;
      4'd3:    return 3'd4;
      4'd4:    return 3'd6;
      4'd5:    return 3'd7;
      4'd6:    return 3'd1;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [2:0] load_f3(input logic [3:0] op);
    case (op)
      4'd0:    return 3'd0;
      4'd1:    return 3'd1;
      4'd2:    return 3'd2;
      4'd3:    return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  function automatic logic [2:0] store_f3(input logic [3:0] op);
    case (op)
      4'd0:    return 3'd0;
      4'd1:    return 3'd1;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [2:0] branch_f3(input logic [3:0] op);
    case (op)
      4'd0:    return 3'd0;
      4'd1:    return 3'd1;
      4'd2:    return 3'd4;
      4'd3:    return 3'd5;
      4'd4:    return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // Builds the 32-bit word for a request; an illegal request yields word 0.
  function automatic enc_t encode(input logic [3:0]  cls,
                                  input logic [3:0]  op,
                                  input logic [4:0]  rd,
                                  input logic [4:0]  rs1,
                                  input logic [4:0]  rs2,
                                  input logic [31:0] imm);
    enc_t e;
    e.legal = (op < op_count(cls));
    e.word  = '0;
    case (cls)
      CLS_R: e.word = {((op == 4'd1 || op == 4'd7) ? 7'h20 : 7'h00),
                       rs2, rs1, r_f3(op), rd, OPC_OP};
      CLS_I: begin
        if (op >= 4'd6) begin
          // Shifts carry shamt in imm[4:0] and the arithmetic flag in funct7.
          e.word = {((op == 4'd8) ? 7'h20 : 7'h00), imm[4:0], rs1, i_f3(op), rd, OPC_OP_IMM};
        end else begin
          e.word = {imm[11:0], rs1, i_f3(op), rd, OPC_OP_IMM};
        end
      end
      CLS_IL:   e.word = {imm[11:0], rs1, load_f3(op), rd, OPC_LOAD};
      CLS_IJ:   e.word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      CLS_IE:   e.word = {11'h000, op[0], 5'd0, 3'b000, 5'd0, OPC_SYSTEM};
      CLS_S:    e.word = {imm[11:5], rs2, rs1, store_f3(op), imm[4:0], OPC_STORE};
      CLS_B:    e.word = {imm[12], imm[10:5], rs2, rs1, branch_f3(op),
                          imm[4:1], imm[11], OPC_BRANCH};
      CLS_J:    e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      CLS_UL:   e.word = {imm[31:12], rd, OPC_LUI};
      CLS_UAPC: e.word = {imm[31:12], rd, OPC_AUIPC};
      default:  e.word = '0;
    endcase
    if (!e.legal) e.word = '0;
    return e;
  endfunction

endpackage

// File: rtl/rv32i_enc_fifo.sv
// Synchronous FIFO with a registered head word and an occupancy count output.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module rv32i_enc_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned  AW      = $clog2(DEPTH);
  localparam logic [AW:0]  DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]  ONE_C   = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_rd_next;

  assign w_do_push = i_push && (r_count != DEPTH_C);
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_rd_next = r_rd_ptr + 1'b1;
  assign o_head    = r_head;
  assign o_count   = r_count;

  // Write the storage array on every accepted push.
  // NOTE: storage is not reset; r_count alone decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers, occupancy and the registered head word.
  // NOTE: state uses <= so every register here sees the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= w_rd_next;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // The incoming word becomes the head when it would be the only entry.
      if (w_do_push && ((r_count == '0) || (w_do_pop && (r_count == ONE_C)))) begin
        r_head <= i_wdata;
      end else if (w_do_pop) begin
        r_head <= r_mem[w_rd_next];
      end
    end
  end

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction source: encodes directed requests or, when idle, LFSR-
// driven legal words, buffers them in a small FIFO and presents them on a
// valid/ready port with an error pulse and a pop counter.
module rv32i_inst_encoder
  import rv32i_enc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] LFSR_POLY  = 32'h8020_0003
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_class,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  input  logic        rand_en,
  input  logic [31:0] seed,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic        inst_err,
  output logic [31:0] inst_cnt
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [31:0] r_lfsr;
  logic        r_err;
  logic [31:0] r_cnt;

  logic [AW:0] w_count;
  logic        w_not_full;
  logic        w_req_fire;
  logic        w_rnd_fire;
  logic        w_rnd_push;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_push_word;
  logic [31:0] w_lfsr_next;
  logic [3:0]  w_rnd_cls;
  logic [3:0]  w_rnd_op;
  logic [31:0] w_rnd_imm;
  enc_t        w_dir_enc;
  enc_t        w_rnd_enc;

  // Handshake is held off during reset and is not widened by a same-cycle pop.
  assign w_not_full = (w_count < DEPTH_C);
  assign req_ready  = HRESETn && w_not_full;
  assign w_req_fire = req_valid && req_ready;

  assign w_dir_enc = encode(req_class, req_op, req_rd, req_rs1, req_rs2, req_imm);

  // Random fields are sliced straight from the LFSR state.
  assign w_rnd_cls = r_lfsr[3:0] % NUM_CLASSES;
  assign w_rnd_op  = op_mod(w_rnd_cls, r_lfsr[7:4]);
  assign w_rnd_imm = {r_lfsr[22:0], r_lfsr[31:23]};
  assign w_rnd_enc = encode(w_rnd_cls, w_rnd_op, r_lfsr[12:8], r_lfsr[17:13],
                            r_lfsr[22:18], w_rnd_imm);

  // A present directed request always blocks random generation, even if stalled.
  assign w_rnd_fire = HRESETn && rand_en && !req_valid && w_not_full;
  assign w_rnd_push = w_rnd_fire && w_rnd_enc.legal;

  assign w_push      = (w_req_fire && w_dir_enc.legal) || w_rnd_push;
  assign w_push_word = w_req_fire ? w_dir_enc.word : w_rnd_enc.word;
  assign w_pop       = inst_valid && inst_ready;

  // Right-shifting Galois step.
  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_POLY : 32'h0);

  rv32i_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clk   (HCLK),
    .i_rst_n (HRESETn),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (w_pop),
    .o_head  (inst),
    .o_count (w_count)
  );

  assign inst_valid = (w_count != '0);
  assign inst_err   = r_err;
  assign inst_cnt   = r_cnt;

  // LFSR loads the seed in reset and steps only when a random word is pushed.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_lfsr <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (w_rnd_push) begin
      r_lfsr <= w_lfsr_next;
    end
  end

  // One-cycle error pulse after an illegal request is accepted.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_err <= 1'b0;
    else          r_err <= w_req_fire && !w_dir_enc.legal;
  end

  // Free-running count of consumed words, wrapping at 2^32.
  always_ff @(posedge HCLK) begin
    if (!HRESETn)   r_cnt <= 32'h0;
    else if (w_pop) r_cnt <= r_cnt + 32'h1;
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Directed bench for rv32i_inst_encoder: hand-encoded vectors, illegal
// requests, back-pressure ordering, reset behaviour and a random-mode run
// checked against an independent RV32I legality decoder.
module tb_rv32i_inst_encoder;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_class;
  logic [3:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        rand_en;
  logic [31:0] seed;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_err;
  logic [31:0] inst_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt;
  logic [31:0] rand_log [16];

  rv32i_inst_encoder #(
    .FIFO_DEPTH (2),
    .LFSR_POLY  (32'h8020_0003)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_class  (req_class),
    .req_op     (req_op),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .rand_en    (rand_en),
    .seed       (seed),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_err   (inst_err),
    .inst_cnt   (inst_cnt)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Independent decode-side legality model for RV32I base encodings.
  function automatic logic legal_rv32i(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'b0110011: return (f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5));
      7'b0010011: begin
        if (f3 == 3'd1)      return f7 == 7'h00;
        else if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
        else                 return 1'b1;
      end
      7'b0000011: return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      7'b1100111: return f3 == 3'd0;
      7'b1110011: return (w == 32'h0000_0073) || (w == 32'h0010_0073);
      7'b0100011: return f3 <= 3'd2;
      7'b1100011: return (f3 != 3'd2) && (f3 != 3'd3);
      7'b1101111, 7'b0110111, 7'b0010111: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_req(input logic [3:0] c, input logic [3:0] o, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    req_class = c;
    req_op    = o;
    req_rd    = d;
    req_rs1   = s1;
    req_rs2   = s2;
    req_imm   = im;
    req_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] c, input logic [3:0] o, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
    drive_req(c, o, d, s1, s2, im);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input logic [31:0] s);
    HRESETn = 1'b0;
    seed    = s;
    tick();
    tick();
    HRESETn = 1'b1;
    exp_cnt = 32'h0;
  endtask

  // Push one request, check the word one cycle later, then pop it.
  task automatic vec(input string tag, input logic [3:0] c, input logic [3:0] o,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [31:0] im, input logic [31:0] exp);
    send(c, o, d, s1, s2, im);
    check({tag, "_valid"}, 32'(inst_valid), 32'd1);
    check(tag, inst, exp);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    exp_cnt++;
    check({tag, "_cnt"}, inst_cnt, exp_cnt);
  endtask

  initial begin
    int popped;
    int cyc;

    // Reset with a request held high: nothing may be accepted.
    rand_en    = 1'b0;
    inst_ready = 1'b0;
    drive_req(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    do_reset(32'h0);
    req_valid = 1'b0;
    HRESETn   = 1'b0;
    tick();
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_err", 32'(inst_err), 32'd0);
    check("rst_cnt", inst_cnt, 32'h0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    HRESETn = 1'b1;
    tick();
    check("post_rst_empty", 32'(inst_valid), 32'd0);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Directed encodings.
    vec("add",    4'd0, 4'd0, 5'd3,  5'd1,  5'd2,  32'h0000_0000, 32'h002081B3);
    vec("sub",    4'd0, 4'd1, 5'd3,  5'd1,  5'd2,  32'h0000_0000, 32'h402081B3);
    vec("addi",   4'd1, 4'd0, 5'd1,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFF00093);
    vec("srai",   4'd1, 4'd8, 5'd5,  5'd6,  5'd0,  32'h0000_0003, 32'h40335293);
    vec("beq",    4'd6, 4'd0, 5'd0,  5'd1,  5'd2,  32'hFFFF_FFFC, 32'hFE208EE3);
    vec("ecall",  4'd4, 4'd0, 5'd7,  5'd9,  5'd4,  32'h0000_0123, 32'h00000073);
    vec("ebreak", 4'd4, 4'd1, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF, 32'h00100073);
    vec("sw",     4'd5, 4'd2, 5'd0,  5'd1,  5'd2,  32'h0000_0008, 32'h0020A423);
    vec("lui",    4'd8, 4'd0, 5'd5,  5'd0,  5'd0,  32'h1234_5ABC, 32'h123452B7);
    vec("jal",    4'd7, 4'd0, 5'd1,  5'd0,  5'd0,  32'h0000_0008, 32'h008000EF);

    // Illegal op index and illegal class: handshaked, error pulse, no push.
    send(4'd0, 4'd12, 5'd1, 5'd1, 5'd1, 32'h0);
    check("ill_op_err", 32'(inst_err), 32'd1);
    check("ill_op_valid", 32'(inst_valid), 32'd0);
    tick();
    check("ill_op_err_drop", 32'(inst_err), 32'd0);
    check("ill_op_cnt", inst_cnt, exp_cnt);
    send(4'd13, 4'd0, 5'd1, 5'd1, 5'd1, 32'h0);
    check("ill_cls_err", 32'(inst_err), 32'd1);
    check("ill_cls_valid", 32'(inst_valid), 32'd0);
    tick();
    check("ill_cls_err_drop", 32'(inst_err), 32'd0);
    check("ill_cls_cnt", inst_cnt, exp_cnt);

    // Reset mid-operation drops a buffered word and clears the counter.
    send(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    check("mid_buffered", 32'(inst_valid), 32'd1);
    do_reset(32'h0);
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_cnt", inst_cnt, 32'h0);

    // Back-pressure: two accepted, third stalls until space opens.
    send(4'd0, 4'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    send(4'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    drive_req(4'd1, 4'd8, 5'd5, 5'd6, 5'd0, 32'h3);
    check("bp_full_ready", 32'(req_ready), 32'd0);
    tick();
    check("bp_still_full", 32'(req_ready), 32'd0);
    check("bp_head", inst, 32'h002081B3);
    tick();
    check("bp_hold", inst, 32'h002081B3);
    inst_ready = 1'b1;
    tick();
    check("bp_w1", inst, 32'hFFF00093);
    check("bp_cnt1", inst_cnt, 32'd1);
    tick();
    req_valid = 1'b0;
    check("bp_w2", inst, 32'h40335293);
    check("bp_cnt2", inst_cnt, 32'd2);
    tick();
    inst_ready = 1'b0;
    check("bp_empty", 32'(inst_valid), 32'd0);
    check("bp_cnt3", inst_cnt, 32'd3);

    // Nonzero seed: first random word is LH x0,0x400(x0).
    rand_en = 1'b1;
    do_reset(32'h0000_0012);
    tick();
    check("seed_valid", 32'(inst_valid), 32'd1);
    check("seed_word", inst, 32'h40001003);

    // Random mode from seed 0 under random back-pressure.
    do_reset(32'h0);
    popped = 0;
    cyc    = 0;
    while (popped < 1000 && cyc < 20000) begin
      inst_ready = 1'($urandom_range(0, 1));
      @(negedge HCLK);
      if (inst_valid && inst_ready) begin
        check("rand_legal", 32'(legal_rv32i(inst)), 32'd1);
        if (popped < 16) rand_log[popped] = inst;
        popped++;
      end
      tick();
      cyc++;
    end
    inst_ready = 1'b0;
    check("rand_popped", 32'(popped), 32'd1000);
    check("rand_cnt", inst_cnt, 32'd1000);
    check("rand_w0", rand_log[0], 32'h20000013);
    check("rand_w1", rand_log[1], 32'h70000067);

    // Same seed, different back-pressure: identical word sequence.
    do_reset(32'h0);
    popped = 0;
    cyc    = 0;
    inst_ready = 1'b1;
    while (popped < 16 && cyc < 200) begin
      @(negedge HCLK);
      if (inst_valid) begin
        check("rand_repeat", inst, rand_log[popped]);
        popped++;
      end
      tick();
      cyc++;
    end
    inst_ready = 1'b0;
    check("repeat_popped", 32'(popped), 32'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32i_inst_encoder.md
# rv32i_inst_encoder

Field-level RV32I instruction encoder and legal-instruction generator. It turns a handshaked request (instruction class, sub-op, registers, immediate) into a 32-bit RV32I word, or, when idle, pseudo-randomly synthesises a legal word from an LFSR. Words are buffered in a small FIFO and presented on a valid/ready port. It drives instruction stimulus into the fetch path of the `riscv_top_ahb3lite` formal and simulation environments, and emits only encodings the decode-side legality check accepts.

## Interface

Parameters:
- `FIFO_DEPTH`, default 2: output buffer entries; must be a power of two and at least 2.
- `LFSR_POLY`, default 32'h8020_0003: Galois feedback taps.

Ports:
- `HCLK`  in  1  clock; all logic on the rising edge.
- `HRESETn`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  directed request present.
- `req_ready`  out  1  request accepted this cycle when both are high.
- `req_class`  in  4  0=R 1=I 2=IL 3=IJ 4=IE 5=S 6=B 7=J 8=UL 9=UAPC; 10–15 illegal.
- `req_op`  in  4  sub-op index within the class (see Operation).
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register fields.
- `req_imm`  in  32  immediate; only the bits the class uses are taken.
- `rand_en`  in  1  enables random generation when no directed request is present.
- `seed`  in  32  LFSR value loaded during reset; 0 loads 32'h1.
- `inst_valid`  out  1  `inst` holds a word.
- `inst_ready`  in  1  consumer takes the word when both are high.
- `inst`  out  32  encoded instruction.
- `inst_err`  out  1  one-cycle pulse: an illegal request was consumed.
- `inst_cnt`  out  32  count of words popped; wraps to 0 after 2^32-1.

## Operation

- Sub-op indices:
  - R: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - I: 0 ADDI, 1 SLTI, 2 SLTIU, 3 XORI, 4 ORI, 5 ANDI, 6 SLLI, 7 SRLI, 8 SRAI.
  - IL: 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU.
  - IJ: 0 JALR. IE: 0 ECALL, 1 EBREAK. S: 0 SB, 1 SH, 2 SW.
  - B: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU.
  - J: 0 JAL. UL: 0 LUI. UAPC: 0 AUIPC.
  - Any other index is illegal.
- Immediate selection:
  - I, IL, IJ, S: `req_imm[11:0]`.
  - Shift ops: shamt = `req_imm[4:0]`; funct7 is 7'h20 for SRAI and 7'h00 otherwise.
  - B: `req_imm[12:1]`. J: `req_imm[20:1]`. Bit 0 is ignored for both.
  - U (LUI, AUIPC): `req_imm[31:12]`.
  - IE: rd, rs1 and imm are forced to 0 (ECALL) or imm forced to 1 (EBREAK). All other request fields are ignored.
- Fields a format does not use are ignored.
- An illegal request is still handshaked. It pushes nothing and raises `inst_err` on the next cycle.
- Source priority for a push:
  - A directed request always wins.
  - Otherwise, if `rand_en=1` and the FIFO is not full, one random word is pushed and the LFSR advances one step.
  - The LFSR advances only on a random push.
- Random field mapping: class = `lfsr[3:0]` mod 10; op = `lfsr[7:4]` mod (ops in that class); rd = `lfsr[12:8]`; rs1 = `lfsr[17:13]`; rs2 = `lfsr[22:18]`; imm = `lfsr` rotated left by 9. Random words are always legal.
- FIFO-level behaviour:
  - `req_ready` = FIFO count < `FIFO_DEPTH`. It is not bypassed by a same-cycle pop.
  - Push and pop in the same cycle leave the count unchanged.
  - A pop with the FIFO empty is impossible because `inst_valid` is 0.
  - `inst_cnt` increments on each pop.

## Timing

- Reset values (`HRESETn` low at an edge): FIFO empty, `inst_valid=0`, `inst=0`, `inst_err=0`, `inst_cnt=0`, LFSR = `seed`, or 1 if `seed` is 0.
- While `HRESETn` is low, handshakes are ignored and nothing is pushed.
- Reset mid-operation discards buffered words.
- Latency: a push at edge N gives `inst_valid=1` with the word after edge N (registered FIFO head), provided the FIFO was empty.
- `inst_err` pulses for exactly one cycle following the accepting edge.
- Words are popped in push order. `inst` must hold steady while `inst_valid=1` and `inst_ready=0`.

## Structure

- Package `rv32i_enc_pkg` holds:
  - the opcode enum and the class enum;
  - per-class op-count and funct tables;
  - the function `encode(class, op, rd, rs1, rs2, imm) -> {legal, word}`;
  - the function `op_mod(class, idx)`.
- Sub-module `rv32i_enc_fifo` is a parameterised synchronous FIFO with registered head and count output.
- The LFSR, arbitration, error pulse and counter live in the top.

## Test plan

- ADD x3,x1,x2 (class 0, op 0, rd 3, rs1 1, rs2 2) -> `inst`=32'h002081B3 one cycle later; `inst_cnt`=1 after the pop.
- ADDI x1,x0,-1 -> 32'hFFF00093. SRAI x5,x6,3 -> 32'h40335293.
- BEQ x1,x2,imm 32'hFFFF_FFFC -> 32'hFE208EE3. ECALL -> 32'h00000073. EBREAK -> 32'h00100073.
- Class 0, op 12 -> `inst_err` high for one cycle, no `inst_valid`, `inst_cnt` unchanged. Class 13 gives the same result.
- `inst_ready=0`, three back-to-back requests -> two accepted and `req_ready=0`. Raise `inst_ready` -> words emerge in order, third accepted, `inst_cnt`=3.
- `rand_en=1`, `seed`=0, 1000 pops under random `inst_ready` -> every word legal per an independent legality model, the sequence is identical across runs, and `inst_cnt`=1000.
